// File: rtl/pie_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pie_tx_sequencer
// Description : Reader-side command sequencer in front of pie_encoder. Takes
//               one command word per handshake, serialises it MSB-first to the
//               encoder, optionally appends CRC-5 on query commands, then
//               times the T1 turnaround and a receive window for the reply.
//               Optional feature macro: PIE_SEQ_CRC5_EN (CRC-5 on queries).
//               T1_CYCLES and RX_WIN_CYCLES must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module pie_tx_sequencer #(
  parameter int MAX_BITS      = 64,
  parameter int T1_CYCLES     = 100,
  parameter int RX_WIN_CYCLES = 2000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [MAX_BITS-1:0]           cmd_data,
  input  logic [$clog2(MAX_BITS+1)-1:0] cmd_len,
  input  logic                          cmd_query,
  input  logic                          cmd_reply,
  input  logic                          abort,
  input  logic                          enc_rdy,
  input  logic                          rx_done,
  output logic                          enc_bit,
  output logic                          enc_en,
  output logic                          enc_preamble,
  output logic                          rx_en,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout
);

  localparam int c_len_w = $clog2(MAX_BITS + 1);
  localparam int c_cnt_w = $clog2(T1_CYCLES + RX_WIN_CYCLES + 1);

  localparam logic [c_len_w-1:0] c_max_len = c_len_w'(MAX_BITS);
  localparam logic [c_len_w-1:0] c_one_len = c_len_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_t1_last = c_cnt_w'(T1_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rx_last = c_cnt_w'(RX_WIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
`ifdef PIE_SEQ_CRC5_EN
    ST_CRC     = 3'd2,
`endif
    ST_TAIL    = 3'd3,
    ST_T1_WAIT = 3'd4,
    ST_RX_WIN  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Command bits left-aligned so the bit currently on the wire sits at the MSB
  logic [MAX_BITS-1:0]   r_shift;
  logic [c_len_w-1:0]    r_remaining;
  logic                  r_query;
  logic                  r_reply;
  logic [c_cnt_w-1:0]    r_cnt;

  logic                  r_enc_bit;
  logic                  r_enc_en;
  logic                  r_enc_preamble;
  logic                  r_rx_en;
  logic                  r_done;
  logic                  r_timeout;

  logic [c_len_w-1:0]    w_len_clamped;
  logic [MAX_BITS-1:0]   w_aligned;
  logic [MAX_BITS-1:0]   w_shift_adv;
  logic                  w_done_nxt;
  logic                  w_timeout_nxt;
  logic                  w_enc_bit_nxt;
  logic                  w_enc_en_nxt;
  logic                  w_rx_en_nxt;
  logic                  w_preamble_nxt;

`ifdef PIE_SEQ_CRC5_EN
  localparam logic [4:0] c_crc_poly = 5'b01001;
  logic [4:0]            r_crc;
  logic [2:0]            r_crc_cnt;
  logic [4:0]            w_crc_fold;

  // CRC-5 value after folding in the bit currently being consumed
  assign w_crc_fold = {r_crc[3:0], 1'b0} ^
                      ((r_crc[4] ^ r_shift[MAX_BITS-1]) ? c_crc_poly : 5'b00000);
`endif

  assign w_len_clamped = (cmd_len > c_max_len) ? c_max_len : cmd_len;
  assign w_aligned     = cmd_data << (c_max_len - w_len_clamped);
  assign w_shift_adv   = r_shift << 1;

  assign cmd_ready    = (r_state == ST_IDLE);
  assign busy         = ~cmd_ready;
  assign enc_bit      = r_enc_bit;
  assign enc_en       = r_enc_en;
  assign enc_preamble = r_enc_preamble;
  assign rx_en        = r_rx_en;
  assign done         = r_done;
  assign timeout      = r_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and next values of the registered outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_done_nxt     = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_enc_bit_nxt  = r_enc_bit;
    w_enc_en_nxt   = 1'b0;
    w_rx_en_nxt    = 1'b0;
    w_preamble_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (w_len_clamped == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_SEND;
            w_enc_bit_nxt = w_aligned[MAX_BITS-1];
          end
        end
      end
      ST_SEND: begin
        if (enc_rdy) begin
          if (r_remaining == c_one_len) begin
`ifdef PIE_SEQ_CRC5_EN
            if (r_query) begin
              w_state_nxt   = ST_CRC;
              w_enc_bit_nxt = w_crc_fold[4];
            end else begin
              w_state_nxt = ST_TAIL;
            end
`else
            w_state_nxt = ST_TAIL;
`endif
          end else begin
            w_enc_bit_nxt = w_shift_adv[MAX_BITS-1];
          end
        end
      end
`ifdef PIE_SEQ_CRC5_EN
      ST_CRC: begin
        if (enc_rdy) begin
          if (r_crc_cnt == 3'd1) begin
            w_state_nxt = ST_TAIL;
          end else begin
            w_enc_bit_nxt = r_crc[3];
          end
        end
      end
`endif
      ST_TAIL: begin
        // This strobe marks the end of the final symbol on the air
        if (enc_rdy) begin
          if (r_reply) begin
            w_state_nxt = ST_T1_WAIT;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_T1_WAIT: begin
        if (r_cnt == c_t1_last) begin
          w_state_nxt = ST_RX_WIN;
        end
      end
      ST_RX_WIN: begin
        // A reply in the last window cycle still counts as a reply
        if (rx_done) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == c_rx_last) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_done_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
    end

    if ((w_state_nxt == ST_SEND) || (w_state_nxt == ST_TAIL)) begin
      w_enc_en_nxt = 1'b1;
    end
`ifdef PIE_SEQ_CRC5_EN
    if (w_state_nxt == ST_CRC) begin
      w_enc_en_nxt = 1'b1;
    end
`endif
    w_rx_en_nxt    = (w_state_nxt == ST_RX_WIN);
    w_preamble_nxt = w_enc_en_nxt & ((r_state == ST_IDLE) ? cmd_query : r_query);
    if (!w_enc_en_nxt) begin
      w_enc_bit_nxt = 1'b0;
    end
  end

  // Command latch, bit shifter, CRC accumulator, phase timer and output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift        <= '0;
      r_remaining    <= '0;
      r_query        <= 1'b0;
      r_reply        <= 1'b0;
      r_cnt          <= '0;
      r_enc_bit      <= 1'b0;
      r_enc_en       <= 1'b0;
      r_enc_preamble <= 1'b0;
      r_rx_en        <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
`ifdef PIE_SEQ_CRC5_EN
      r_crc          <= '0;
      r_crc_cnt      <= '0;
`endif
    end else begin
      r_enc_bit      <= w_enc_bit_nxt;
      r_enc_en       <= w_enc_en_nxt;
      r_enc_preamble <= w_preamble_nxt;
      r_rx_en        <= w_rx_en_nxt;
      r_done         <= w_done_nxt;
      r_timeout      <= w_timeout_nxt;

      if ((r_state == ST_IDLE) && cmd_valid) begin
        r_shift     <= w_aligned;
        r_remaining <= w_len_clamped;
        r_query     <= cmd_query;
        r_reply     <= cmd_reply;
`ifdef PIE_SEQ_CRC5_EN
        r_crc       <= c_crc_poly;
`endif
      end else if ((r_state == ST_SEND) && enc_rdy) begin
        r_shift     <= w_shift_adv;
        r_remaining <= r_remaining - c_one_len;
`ifdef PIE_SEQ_CRC5_EN
        r_crc       <= w_crc_fold;
        r_crc_cnt   <= 3'd5;
`endif
      end
`ifdef PIE_SEQ_CRC5_EN
      else if ((r_state == ST_CRC) && enc_rdy) begin
        r_crc     <= {r_crc[3:0], 1'b0};
        r_crc_cnt <= r_crc_cnt - 3'd1;
      end
`endif

      if (((r_state == ST_T1_WAIT) || (r_state == ST_RX_WIN)) && (w_state_nxt == r_state)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pie_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pie_tx_sequencer
// Description : Self-checking bench for pie_tx_sequencer. Follows
//               PIE_SEQ_CRC5_EN so it matches the RTL build it is paired with.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pie_tx_sequencer;

  localparam int MAX_BITS = 64;
  localparam int T1       = 100;
  localparam int RXW      = 2000;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [MAX_BITS-1:0] cmd_data;
  logic [LEN_W-1:0]    cmd_len;
  logic                cmd_query;
  logic                cmd_reply;
  logic                abort;
  logic                enc_rdy;
  logic                rx_done;
  logic                enc_bit;
  logic                enc_en;
  logic                enc_preamble;
  logic                rx_en;
  logic                busy;
  logic                done;
  logic                timeout;

  int checks   = 0;
  int failures = 0;

  bit   cap_bits[$];
  bit   exp_q[$];
  int   cap_rdys;
  int   cap_pre_err;
  bit   cap_timed_out;
  bit   cap_fell_on_rdy;
  logic cap_en_first;
  logic cap_done;
  logic cap_ready;
  logic cap_timeout;

  always #5 clk = ~clk;

  pie_tx_sequencer #(
    .MAX_BITS     (MAX_BITS),
    .T1_CYCLES    (T1),
    .RX_WIN_CYCLES(RXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_len     (cmd_len),
    .cmd_query   (cmd_query),
    .cmd_reply   (cmd_reply),
    .abort       (abort),
    .enc_rdy     (enc_rdy),
    .rx_done     (rx_done),
    .enc_bit     (enc_bit),
    .enc_en      (enc_en),
    .enc_preamble(enc_preamble),
    .rx_en       (rx_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bits on air = data[n-1]..data[0], then CRC-5 MSB-first on queries
  function automatic void model_bits(input logic [MAX_BITS-1:0] data, input int len, input bit query);
    int n;
    logic [4:0] crc;
    bit fb;
    n = (len > MAX_BITS) ? MAX_BITS : len;
    exp_q.delete();
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(data[i]);
`ifdef PIE_SEQ_CRC5_EN
    if (query && n > 0) begin
      crc = 5'b01001;
      foreach (exp_q[j]) begin
        fb  = crc[4] ^ exp_q[j];
        crc = {crc[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
      end
      for (int k = 4; k >= 0; k--) exp_q.push_back(crc[k]);
    end
`else
    if (query) n = n;
`endif
  endfunction

  // Drive one command and play the encoder with an enc_rdy strobe every 'gap' clocks
  task automatic send_cmd(input logic [MAX_BITS-1:0] data, input int len, input bit query,
                          input bit reply, input int gap);
    int cyc;
    int ph;
    bit last_rdy;
    cap_bits.delete();
    cap_rdys = 0; cap_pre_err = 0; cap_timed_out = 0; cap_fell_on_rdy = 0;
    cmd_valid = 1'b1; cmd_data = data; cmd_len = LEN_W'(len);
    cmd_query = query; cmd_reply = reply;
    tick();
    cmd_valid = 1'b0;
    cap_en_first = enc_en;
    cyc = 0; ph = 0; last_rdy = 0;
    while (enc_en === 1'b1 && cyc < 5000) begin
      if (enc_preamble !== query) cap_pre_err++;
      ph++;
      if (ph >= gap) begin
        ph = 0;
        enc_rdy = 1'b1;
        cap_bits.push_back(enc_bit);
        cap_rdys++;
      end else begin
        enc_rdy = 1'b0;
      end
      last_rdy = enc_rdy;
      tick();
      enc_rdy = 1'b0;
      cyc++;
    end
    cap_timed_out   = (cyc >= 5000);
    cap_fell_on_rdy = last_rdy && (enc_en === 1'b0);
    cap_done    = done;
    cap_ready   = cmd_ready;
    cap_timeout = timeout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, busy, enc_en, enc_bit, enc_preamble, rx_en, done, timeout} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {cmd_ready, busy, enc_en, enc_bit, enc_preamble, rx_en, done, timeout}, 8'b1000_0000);
    end
    rst = 1'b0;
    enc_rdy = 1'b1;
    tick();
    tick();
    enc_rdy = 1'b0;
    checks++;
    if ({cmd_ready, enc_en, done} !== 3'b100) begin
      failures++;
      $display("FAIL idle_ignores_enc_rdy got=%b exp=%b", {cmd_ready, enc_en, done}, 3'b100);
    end
  endtask

  task automatic test_basic();
    send_cmd(64'hB, 4, 1'b0, 1'b0, 16);
    model_bits(64'hB, 4, 1'b0);
    checks++;
    if (cap_en_first !== 1'b1) begin
      failures++; $display("FAIL basic_en_latency got=%b exp=1", cap_en_first);
    end
    checks++;
    if (cap_rdys !== 5) begin
      failures++; $display("FAIL basic_rdy_count got=%0d exp=5", cap_rdys);
    end
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL basic_bit%0d got=%b exp=%b", i, g, exp_q[i]);
      end
    end
    checks++;
    if ({cap_fell_on_rdy, cap_done, cap_timeout, cap_ready} !== 4'b1101) begin
      failures++;
      $display("FAIL basic_end got fell/done/tmo/rdy=%b exp=1101",
               {cap_fell_on_rdy, cap_done, cap_timeout, cap_ready});
    end
    tick();
    checks++;
    if ({done, timeout} !== 2'b00) begin
      failures++; $display("FAIL basic_done_single got=%b exp=00", {done, timeout});
    end
  endtask

  task automatic test_crc_query();
    for (int v = 0; v < 2; v++) begin
      logic [MAX_BITS-1:0] d;
      d = MAX_BITS'(v);
      send_cmd(d, 1, 1'b1, 1'b0, 3);
`ifdef PIE_SEQ_CRC5_EN
      if (v == 0) exp_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      else        exp_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
      exp_q = '{d[0]};
`endif
      checks++;
      if (cap_rdys !== exp_q.size() + 1) begin
        failures++; $display("FAIL crc_rdy_count data=%0d got=%0d exp=%0d", v, cap_rdys, exp_q.size() + 1);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic g;
        g = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
        checks++;
        if (g !== exp_q[i]) begin
          failures++; $display("FAIL crc_bit data=%0d idx=%0d got=%b exp=%b", v, i, g, exp_q[i]);
        end
      end
      checks++;
      if (cap_pre_err !== 0 || cap_done !== 1'b1) begin
        failures++; $display("FAIL crc_preamble_done preamble_errs=%0d done=%b exp 0/1", cap_pre_err, cap_done);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [MAX_BITS-1:0] d;
      int len, gap;
      bit q;
      d   = {$urandom, $urandom};
      len = $urandom_range(1, 20);
      gap = $urandom_range(1, 4);
      q   = 1'($urandom_range(0, 1));
      model_bits(d, len, q);
      send_cmd(d, len, q, 1'b0, gap);
      checks++;
      if (cap_timed_out || cap_rdys !== exp_q.size() + 1) begin
        failures++; $display("FAIL rand%0d_rdy_count got=%0d exp=%0d", t, cap_rdys, exp_q.size() + 1);
      end
      checks++;
      if (cap_pre_err !== 0 || cap_done !== 1'b1 || cap_fell_on_rdy !== 1'b1) begin
        failures++; $display("FAIL rand%0d_end preamble_errs=%0d done=%b fell=%b exp 0/1/1",
                             t, cap_pre_err, cap_done, cap_fell_on_rdy);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic g;
        g = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
        checks++;
        if (g !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_bit%0d got=%b exp=%b", t, i, g, exp_q[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_reply_timeout();
    int n;
    send_cmd(64'h5, 3, 1'b0, 1'b1, 2);
    checks++;
    if ({cap_done, cap_ready, rx_en} !== 3'b000) begin
      failures++; $display("FAIL tmo_after_tail got done/rdy/rx=%b exp=000", {cap_done, cap_ready, rx_en});
    end
    n = 0;
    while (rx_en !== 1'b1 && n < 1000) begin tick(); n++; end
    checks++;
    if (n !== T1) begin
      failures++; $display("FAIL tmo_t1_length got=%0d exp=%0d", n, T1);
    end
    n = 0;
    while (rx_en === 1'b1 && n < 5000) begin tick(); n++; end
    checks++;
    if (n !== RXW) begin
      failures++; $display("FAIL tmo_window_length got=%0d exp=%0d", n, RXW);
    end
    checks++;
    if ({timeout, done, cmd_ready} !== 3'b101) begin
      failures++; $display("FAIL tmo_pulse got tmo/done/rdy=%b exp=101", {timeout, done, cmd_ready});
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      failures++; $display("FAIL tmo_single got=%b exp=0", timeout);
    end
  endtask

  task automatic test_reply_rx_done();
    int n;
    send_cmd(64'h2, 2, 1'b0, 1'b1, 1);
    n = 0;
    while (rx_en !== 1'b1 && n < 1000) begin
      rx_done = (n == 5);
      tick();
      rx_done = 1'b0;
      n++;
    end
    checks++;
    if (n !== T1) begin
      failures++; $display("FAIL rxd_t1_ignores_rx_done got=%0d exp=%0d", n, T1);
    end
    repeat (10) tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    checks++;
    if ({done, rx_en, timeout, cmd_ready} !== 4'b1001) begin
      failures++; $display("FAIL rxd_done got done/rx/tmo/rdy=%b exp=1001", {done, rx_en, timeout, cmd_ready});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL rxd_done_single got=%b exp=0", done);
    end
  endtask

  task automatic test_abort_and_reset();
    int n, ph, cyc;
    bit pulse;
    cmd_valid = 1'b1; cmd_data = {$urandom, $urandom}; cmd_len = LEN_W'(8);
    cmd_query = 1'b1; cmd_reply = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0; ph = 0; cyc = 0;
    while (n < 3 && cyc < 200) begin
      ph++;
      if (ph >= 4) begin ph = 0; enc_rdy = 1'b1; n++; end
      tick();
      enc_rdy = 1'b0;
      cyc++;
    end
    checks++;
    if (enc_en !== 1'b1) begin
      failures++; $display("FAIL abort_still_sending got=%b exp=1", enc_en);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({cmd_ready, busy, enc_en, enc_preamble, rx_en, done, timeout} !== 7'b1000000) begin
      failures++; $display("FAIL abort_outputs got=%b exp=1000000",
                           {cmd_ready, busy, enc_en, enc_preamble, rx_en, done, timeout});
    end
    pulse = 0;
    enc_rdy = 1'b1;
    repeat (20) begin
      tick();
      if (done !== 1'b0 || timeout !== 1'b0 || enc_en !== 1'b0 || rx_en !== 1'b0) pulse = 1;
    end
    enc_rdy = 1'b0;
    checks++;
    if (pulse !== 1'b0) begin
      failures++; $display("FAIL abort_no_pulse got=%b exp=0", pulse);
    end

    send_cmd(64'h1, 2, 1'b0, 1'b1, 1);
    n = 0;
    while (rx_en !== 1'b1 && n < 1000) begin tick(); n++; end
    repeat (50) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, busy, enc_en, enc_bit, enc_preamble, rx_en, done, timeout} !== 8'b1000_0000) begin
      failures++; $display("FAIL rst_mid_rx got=%b exp=10000000",
                           {cmd_ready, busy, enc_en, enc_bit, enc_preamble, rx_en, done, timeout});
    end
    rst = 1'b0;
    pulse = 0;
    repeat (RXW + 10) begin
      tick();
      if (done !== 1'b0 || timeout !== 1'b0 || rx_en !== 1'b0) pulse = 1;
    end
    checks++;
    if (pulse !== 1'b0) begin
      failures++; $display("FAIL rst_no_pulse got=%b exp=0", pulse);
    end

    model_bits(64'h35, 6, 1'b0);
    send_cmd(64'h35, 6, 1'b0, 1'b0, 2);
    checks++;
    if (cap_rdys !== exp_q.size() + 1 || cap_done !== 1'b1) begin
      failures++; $display("FAIL post_abort_cmd rdys=%0d done=%b exp=%0d/1", cap_rdys, cap_done, exp_q.size() + 1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic g;
      g = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL post_abort_bit%0d got=%b exp=%b", i, g, exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_len_bounds();
    logic [MAX_BITS-1:0] d;
    cmd_valid = 1'b1; cmd_data = '1; cmd_len = '0; cmd_query = 1'b1; cmd_reply = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({done, enc_en, cmd_ready} !== 3'b101) begin
      failures++; $display("FAIL len0_done got done/en/rdy=%b exp=101", {done, enc_en, cmd_ready});
    end
    tick();
    checks++;
    if ({done, enc_en, rx_en} !== 3'b000) begin
      failures++; $display("FAIL len0_after got done/en/rx=%b exp=000", {done, enc_en, rx_en});
    end

    d = {$urandom, $urandom};
    model_bits(d, MAX_BITS + 5, 1'b0);
    send_cmd(d, MAX_BITS + 5, 1'b0, 1'b0, 1);
    checks++;
    if (cap_rdys !== MAX_BITS + 1) begin
      failures++; $display("FAIL clamp_rdy_count got=%0d exp=%0d", cap_rdys, MAX_BITS + 1);
    end
    for (int i = 0; i < MAX_BITS; i++) begin
      logic g;
      g = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL clamp_bit%0d got=%b exp=%b", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic first_done;
    send_cmd(64'h6, 3, 1'b0, 1'b0, 2);
    first_done = cap_done;
    model_bits(64'h9, 4, 1'b1);
    send_cmd(64'h9, 4, 1'b1, 1'b0, 2);
    checks++;
    if ({first_done, cap_en_first} !== 2'b11) begin
      failures++; $display("FAIL b2b_accept got done/en=%b exp=11", {first_done, cap_en_first});
    end
    checks++;
    if (cap_rdys !== exp_q.size() + 1 || cap_pre_err !== 0) begin
      failures++; $display("FAIL b2b_len rdys=%0d preamble_errs=%0d exp=%0d/0",
                           cap_rdys, cap_pre_err, exp_q.size() + 1);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic g;
      g = (i < cap_bits.size()) ? cap_bits[i] : 1'bx;
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, g, exp_q[i]);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0;
    cmd_query = 1'b0; cmd_reply = 1'b0; abort = 1'b0; enc_rdy = 1'b0; rx_done = 1'b0;
    test_reset();
    test_basic();
    test_crc_query();
    test_random();
    test_reply_timeout();
    test_reply_rx_done();
    test_abort_and_reset();
    test_len_bounds();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
